// File: rtl/sys_ctrl.sv
// Command sequencer: decodes 1-4 byte frames from the receive path into register-file
// and ALU operations, returns responses to the TX FIFO and gates the ALU clock.
module sys_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic                    rx_valid,
    output logic [ADDR_WIDTH-1:0]   rf_addr,
    output logic                    rf_wr_en,
    output logic                    rf_rd_en,
    output logic [DATA_WIDTH-1:0]   rf_wr_data,
    input  logic [DATA_WIDTH-1:0]   rf_rd_data,
    input  logic                    rf_rd_valid,
    output logic                    alu_en,
    output logic [FUN_WIDTH-1:0]    alu_fun,
    input  logic [2*DATA_WIDTH-1:0] alu_out,
    input  logic                    alu_out_valid,
    output logic                    clk_gate_en,
    input  logic                    fifo_full,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_valid
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
        ALU_FUN, ALU_WAIT, TX_SEND, TX_HI
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   rf_addr_nxt;
    logic [DATA_WIDTH-1:0]   rf_wr_data_nxt;
    logic [FUN_WIDTH-1:0]    alu_fun_nxt;
    logic                    rf_wr_en_nxt, rf_rd_en_nxt, alu_en_nxt, clk_gate_en_nxt;
    logic [DATA_WIDTH-1:0]   resp_lo, resp_lo_nxt, resp_hi, resp_hi_nxt;
    logic                    resp_two, resp_two_nxt;

    always_comb begin
        state_nxt       = state;
        rf_addr_nxt     = rf_addr;
        rf_wr_data_nxt  = rf_wr_data;
        alu_fun_nxt     = alu_fun;
        rf_wr_en_nxt    = 1'b0;
        rf_rd_en_nxt    = 1'b0;
        alu_en_nxt      = 1'b0;
        clk_gate_en_nxt = clk_gate_en;
        resp_lo_nxt     = resp_lo;
        resp_hi_nxt     = resp_hi;
        resp_two_nxt    = resp_two;

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_WR:     state_nxt = WR_ADDR;
                        CMD_RD:     state_nxt = RD_ADDR;
                        CMD_ALU_OP: state_nxt = OP_A;
                        CMD_ALU: begin
                            state_nxt       = ALU_FUN;
                            clk_gate_en_nxt = 1'b1;
                        end
                        default:    state_nxt = IDLE;
                    endcase
                end
            end
            WR_ADDR: if (rx_valid) begin
                rf_addr_nxt = rx_data[ADDR_WIDTH-1:0];
                state_nxt   = WR_DATA;
            end
            WR_DATA: if (rx_valid) begin
                rf_wr_data_nxt = rx_data;
                rf_wr_en_nxt   = 1'b1;
                state_nxt      = IDLE;
            end
            RD_ADDR: if (rx_valid) begin
                rf_addr_nxt  = rx_data[ADDR_WIDTH-1:0];
                rf_rd_en_nxt = 1'b1;
                state_nxt    = RD_WAIT;
            end
            RD_WAIT: if (rf_rd_valid) begin
                resp_lo_nxt  = rf_rd_data;
                resp_two_nxt = 1'b0;
                state_nxt    = TX_SEND;
            end
            // Operands are staged in register-file words 0 and 1 for the ALU
            OP_A: if (rx_valid) begin
                rf_addr_nxt    = '0;
                rf_wr_data_nxt = rx_data;
                rf_wr_en_nxt   = 1'b1;
                state_nxt      = OP_B;
            end
            OP_B: if (rx_valid) begin
                rf_addr_nxt     = ADDR_WIDTH'(1);
                rf_wr_data_nxt  = rx_data;
                rf_wr_en_nxt    = 1'b1;
                clk_gate_en_nxt = 1'b1;
                state_nxt       = ALU_FUN;
            end
            ALU_FUN: if (rx_valid) begin
                alu_fun_nxt = rx_data[FUN_WIDTH-1:0];
                alu_en_nxt  = 1'b1;
                state_nxt   = ALU_WAIT;
            end
            ALU_WAIT: if (alu_out_valid) begin
                resp_lo_nxt  = alu_out[DATA_WIDTH-1:0];
                resp_hi_nxt  = alu_out[2*DATA_WIDTH-1:DATA_WIDTH];
                resp_two_nxt = 1'b1;
                state_nxt    = TX_SEND;
            end
            TX_SEND: if (!fifo_full) state_nxt = resp_two ? TX_HI : IDLE;
            TX_HI: if (!fifo_full) begin
                clk_gate_en_nxt = 1'b0;
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            rf_addr     <= '0;
            rf_wr_data  <= '0;
            alu_fun     <= '0;
            rf_wr_en    <= 1'b0;
            rf_rd_en    <= 1'b0;
            alu_en      <= 1'b0;
            clk_gate_en <= 1'b0;
            resp_lo     <= '0;
            resp_hi     <= '0;
            resp_two    <= 1'b0;
        end else begin
            state       <= state_nxt;
            rf_addr     <= rf_addr_nxt;
            rf_wr_data  <= rf_wr_data_nxt;
            alu_fun     <= alu_fun_nxt;
            rf_wr_en    <= rf_wr_en_nxt;
            rf_rd_en    <= rf_rd_en_nxt;
            alu_en      <= alu_en_nxt;
            clk_gate_en <= clk_gate_en_nxt;
            resp_lo     <= resp_lo_nxt;
            resp_hi     <= resp_hi_nxt;
            resp_two    <= resp_two_nxt;
        end
    end

    // The FIFO write strobe follows fifo_full combinationally so a full FIFO is never written
    assign tx_valid = ((state == TX_SEND) || (state == TX_HI)) && !fifo_full;

    always_comb begin
        tx_data = '0;
        if (state == TX_SEND)
            tx_data = resp_lo;
        else if (state == TX_HI)
            tx_data = resp_hi;
    end

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed-vector bench for sys_ctrl: per-cycle table of inputs and expected outputs,
// plus hand sequences for FIFO back-pressure and mid-frame reset.
module tb_sys_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [3:0]  rf_addr;
    logic        rf_wr_en, rf_rd_en;
    logic [7:0]  rf_wr_data;
    logic [7:0]  rf_rd_data = '0;
    logic        rf_rd_valid = 1'b0;
    logic        alu_en;
    logic [3:0]  alu_fun;
    logic [15:0] alu_out = '0;
    logic        alu_out_valid = 1'b0;
    logic        clk_gate_en;
    logic        fifo_full = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;

    sys_ctrl dut (
        .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
        .rf_addr(rf_addr), .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
        .rf_wr_data(rf_wr_data), .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
        .alu_en(alu_en), .alu_fun(alu_fun), .alu_out(alu_out),
        .alu_out_valid(alu_out_valid), .clk_gate_en(clk_gate_en),
        .fifo_full(fifo_full), .tx_data(tx_data), .tx_valid(tx_valid)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rxv;
        logic [7:0]  rxd;
        logic        rdv;
        logic [7:0]  rdd;
        logic        aov;
        logic [15:0] ao;
        logic        ff;
        logic [28:0] exp;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;
    int excl_err = 0;
    logic [7:0] txq[$];
    logic [28:0] act;

    assign act = {rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
                  clk_gate_en, tx_valid, tx_data};

    // Model of the TX FIFO write port and strobe exclusivity, sampled at the active edge
    always @(posedge CLK) begin
        if (tx_valid === 1'b1) txq.push_back(tx_data);
        if ($countones({rf_wr_en, rf_rd_en, alu_en, tx_valid}) > 1) excl_err++;
    end

    function automatic logic [28:0] E(input logic wr, input logic rd, input logic [3:0] addr,
                                      input logic [7:0] wd, input logic ae, input logic [3:0] fun,
                                      input logic cg, input logic tv, input logic [7:0] td);
        return {wr, rd, addr, wd, ae, fun, cg, tv, td};
    endfunction

    function automatic vec_t V(input logic rxv, input logic [7:0] rxd, input logic [28:0] e,
                               input logic rdv = 1'b0, input logic [7:0] rdd = 8'h00,
                               input logic aov = 1'b0, input logic [15:0] ao = 16'h0000,
                               input logic ff = 1'b0);
        vec_t t;
        t.rxv = rxv; t.rxd = rxd; t.rdv = rdv; t.rdd = rdd;
        t.aov = aov; t.ao = ao; t.ff = ff; t.exp = e;
        return t;
    endfunction

    task automatic check(input string nm, input logic [28:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {wr,rd,addr,wdata,alu_en,fun,cge,txv,txd}=%h expected %h",
                     nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Inputs are applied on a falling edge and outputs checked on the next falling edge
    task automatic run_vec(input vec_t t, input string nm);
        rx_valid      = t.rxv;
        rx_data       = t.rxd;
        rf_rd_valid   = t.rdv;
        rf_rd_data    = t.rdd;
        alu_out_valid = t.aov;
        alu_out       = t.ao;
        fifo_full     = t.ff;
        @(negedge CLK);
        check(nm, t.exp);
        rx_valid      = 1'b0;
        rf_rd_valid   = 1'b0;
        alu_out_valid = 1'b0;
    endtask

    vec_t tbl[19];
    logic [7:0] exp_tx[5];

    initial begin
        tbl[0]  = V(1'b1, 8'hAA, E(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0, 8'h00));
        tbl[1]  = V(1'b1, 8'h05, E(0, 0, 4'h5, 8'h00, 0, 4'h0, 0, 0, 8'h00));
        tbl[2]  = V(1'b1, 8'h3C, E(1, 0, 4'h5, 8'h3C, 0, 4'h0, 0, 0, 8'h00));
        tbl[3]  = V(1'b0, 8'h00, E(0, 0, 4'h5, 8'h3C, 0, 4'h0, 0, 0, 8'h00));
        tbl[4]  = V(1'b1, 8'h77, E(0, 0, 4'h5, 8'h3C, 0, 4'h0, 0, 0, 8'h00));
        tbl[5]  = V(1'b0, 8'h00, E(0, 0, 4'h5, 8'h3C, 0, 4'h0, 0, 0, 8'h00));
        tbl[6]  = V(1'b1, 8'hBB, E(0, 0, 4'h5, 8'h3C, 0, 4'h0, 0, 0, 8'h00));
        tbl[7]  = V(1'b1, 8'h07, E(0, 1, 4'h7, 8'h3C, 0, 4'h0, 0, 0, 8'h00));
        tbl[8]  = V(1'b0, 8'h00, E(0, 0, 4'h7, 8'h3C, 0, 4'h0, 0, 0, 8'h00));
        tbl[9]  = V(1'b0, 8'h00, E(0, 0, 4'h7, 8'h3C, 0, 4'h0, 0, 1, 8'h5A), 1'b1, 8'h5A);
        tbl[10] = V(1'b0, 8'h00, E(0, 0, 4'h7, 8'h3C, 0, 4'h0, 0, 0, 8'h00));
        tbl[11] = V(1'b1, 8'hCC, E(0, 0, 4'h7, 8'h3C, 0, 4'h0, 0, 0, 8'h00));
        tbl[12] = V(1'b1, 8'h10, E(1, 0, 4'h0, 8'h10, 0, 4'h0, 0, 0, 8'h00));
        tbl[13] = V(1'b1, 8'h20, E(1, 0, 4'h1, 8'h20, 0, 4'h0, 1, 0, 8'h00));
        tbl[14] = V(1'b1, 8'h01, E(0, 0, 4'h1, 8'h20, 1, 4'h1, 1, 0, 8'h00));
        tbl[15] = V(1'b1, 8'h55, E(0, 0, 4'h1, 8'h20, 0, 4'h1, 1, 0, 8'h00));
        tbl[16] = V(1'b0, 8'h00, E(0, 0, 4'h1, 8'h20, 0, 4'h1, 1, 1, 8'h30),
                    1'b0, 8'h00, 1'b1, 16'h0030);
        tbl[17] = V(1'b0, 8'h00, E(0, 0, 4'h1, 8'h20, 0, 4'h1, 1, 1, 8'h00));
        tbl[18] = V(1'b0, 8'h00, E(0, 0, 4'h1, 8'h20, 0, 4'h1, 0, 0, 8'h00));

        exp_tx[0] = 8'h5A; exp_tx[1] = 8'h30; exp_tx[2] = 8'h00;
        exp_tx[3] = 8'hB2; exp_tx[4] = 8'hA1;

        repeat (3) @(negedge CLK);
        check("reset_state", 29'h0);
        RST = 1'b1;

        for (int i = 0; i < 19; i++)
            run_vec(tbl[i], $sformatf("vec%0d", i));

        // ALU with current operands, FIFO full for several cycles after the result
        run_vec(V(1'b1, 8'hDD, E(0, 0, 4'h1, 8'h20, 0, 4'h1, 1, 0, 8'h00)), "dd_cmd");
        run_vec(V(1'b1, 8'h02, E(0, 0, 4'h1, 8'h20, 1, 4'h2, 1, 0, 8'h00)), "dd_fun");
        run_vec(V(1'b0, 8'h00, E(0, 0, 4'h1, 8'h20, 0, 4'h2, 1, 0, 8'hB2),
                  1'b0, 8'h00, 1'b1, 16'hA1B2, 1'b1), "dd_result_full");
        for (int i = 0; i < 5; i++)
            run_vec(V(1'b0, 8'h00, E(0, 0, 4'h1, 8'h20, 0, 4'h2, 1, 0, 8'hB2),
                      1'b0, 8'h00, 1'b0, 16'hA1B2, 1'b1), $sformatf("dd_hold%0d", i));
        check_int("dd_nothing_sent_while_full", txq.size(), 3);
        run_vec(V(1'b0, 8'h00, E(0, 0, 4'h1, 8'h20, 0, 4'h2, 1, 1, 8'hA1),
                  1'b0, 8'h00, 1'b0, 16'hA1B2, 1'b0), "dd_lo_sent");
        run_vec(V(1'b0, 8'h00, E(0, 0, 4'h1, 8'h20, 0, 4'h2, 0, 0, 8'h00)), "dd_hi_sent");

        // Reset in the middle of a write frame, then a clean write
        run_vec(V(1'b1, 8'hAA, E(0, 0, 4'h1, 8'h20, 0, 4'h2, 0, 0, 8'h00)), "rst_wr_cmd");
        run_vec(V(1'b1, 8'h03, E(0, 0, 4'h3, 8'h20, 0, 4'h2, 0, 0, 8'h00)), "rst_wr_addr");
        #2 RST = 1'b0;
        #1 check("mid_frame_reset", 29'h0);
        @(negedge CLK);
        RST = 1'b1;
        run_vec(V(1'b1, 8'hAA, E(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0, 8'h00)), "post_rst_cmd");
        run_vec(V(1'b1, 8'h01, E(0, 0, 4'h1, 8'h00, 0, 4'h0, 0, 0, 8'h00)), "post_rst_addr");
        run_vec(V(1'b1, 8'hFF, E(1, 0, 4'h1, 8'hFF, 0, 4'h0, 0, 0, 8'h00)), "post_rst_data");
        run_vec(V(1'b0, 8'h00, E(0, 0, 4'h1, 8'hFF, 0, 4'h0, 0, 0, 8'h00)), "post_rst_idle");

        check_int("tx_byte_count", txq.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < txq.size())
                check_int($sformatf("tx_byte%0d", i), int'(txq[i]), int'(exp_tx[i]));
        end
        check_int("strobe_exclusive_violations", excl_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
